// File: rtl/commute_game_ctrl_if.sv
// rtl/commute_game_ctrl_if.sv - player-input handshake bundle for the commute-game round sequencer
interface commute_game_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] speed;
  logic [1:0] breakfast;
  logic [1:0] movement;
  logic       weather;

  // Front end drives choices, controller answers with ready.
  modport master (
    output in_valid, speed, breakfast, movement, weather,
    input  in_ready
  );

  modport slave (
    input  in_valid, speed, breakfast, movement, weather,
    output in_ready
  );
endinterface

// File: rtl/commute_game_ctrl.sv
// rtl/commute_game_ctrl.sv - round sequencer: captures choices, drives stage-1 evaluator, keeps score/lives
module commute_game_ctrl #(
  parameter int unsigned ROUNDS    = 5,
  parameter int unsigned LIVES     = 3,
  parameter logic [6:0]  SEED      = 7'h5A,
  parameter int unsigned WIN_SCORE = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  commute_game_ctrl_if.slave        player,
  output logic [6:0]                s1_speed,
  output logic [1:0]                s1_breakfast,
  output logic [1:0]                s1_movement,
  output logic                      s1_weather,
  output logic [6:0]                s1_random,
  input  logic [1:0]                s1_bonus,
  input  logic                      s1_pass,
  output logic [7:0]                score,
  output logic [1:0]                lives,
  output logic [7:0]                round,
  output logic                      busy,
  output logic                      done,
  output logic                      win
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_WAIT,
    S_EVAL,
    S_CHECK,
    S_DONE
  } state_t;

  state_t     state, state_nxt;
  logic [6:0] lfsr;
  logic       in_ready_c;
  logic       take;
  logic [8:0] score_sum;
  logic       score_ok;
  logic       last_round;

  assign player.in_ready = in_ready_c;
  assign take            = player.in_valid & in_ready_c;
  // One extra bit catches the carry so the score can saturate at 255.
  assign score_sum       = {1'b0, score} + {7'd0, s1_bonus};
  assign score_ok        = (32'(score) >= WIN_SCORE);
  assign last_round      = (round == ROUNDS[7:0]);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; lives exhausted wins over the round limit.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_INIT;
      S_INIT:         state_nxt = S_WAIT;
      S_WAIT:         if (take) state_nxt = S_EVAL;
      S_EVAL:         state_nxt = S_CHECK;
      S_CHECK: begin
        if (lives == 2'd0)   state_nxt = S_DONE;
        else if (last_round) state_nxt = S_DONE;
        else                 state_nxt = S_WAIT;
      end
      default:        state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    in_ready_c = 1'b0;
    busy       = 1'b0;
    case (state)
      S_INIT, S_EVAL, S_CHECK: busy = 1'b1;
      S_WAIT: begin
        busy       = 1'b1;
        in_ready_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: capture, scoring, LFSR stepping and the game-over flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr         <= SEED;
      s1_speed     <= 7'd0;
      s1_breakfast <= 2'd0;
      s1_movement  <= 2'd0;
      s1_weather   <= 1'b0;
      s1_random    <= 7'd0;
      score        <= 8'd0;
      lives        <= 2'd0;
      round        <= 8'd0;
      done         <= 1'b0;
      win          <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          score <= 8'd0;
          round <= 8'd0;
          lives <= LIVES[1:0];
          done  <= 1'b0;
          win   <= 1'b0;
        end
        S_WAIT: begin
          if (take) begin
            s1_speed     <= player.speed;
            s1_breakfast <= player.breakfast;
            s1_movement  <= player.movement;
            s1_weather   <= player.weather;
            s1_random    <= lfsr;
          end
        end
        S_EVAL: begin
          score <= score_sum[8] ? 8'hFF : score_sum[7:0];
          if (!s1_pass) lives <= lives - 2'd1;
          round <= round + 8'd1;
          lfsr  <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        end
        S_CHECK: begin
          if (state_nxt == S_DONE) begin
            done <= 1'b1;
            win  <= (lives != 2'd0) && score_ok;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
